spi_peripheral_burst: RTL



---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_sync_edge.sv | 37 +++
 rtl/spi_peripheral_burst.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the burst SPI target.
// Mode encoding is {CPOL, CPHA}; the command word is always eight bits wide.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_WRITE,
        ST_READ
    } state_t;

    typedef logic [1:0] spi_mode_t;

    localparam int CMD_W      = 8;
    localparam int CMD_RW_BIT = 7;

    // Modes 0 and 3 capture MOSI on the rising SCK edge, modes 1 and 2 on the falling edge.
    function automatic logic samples_on_rise(input spi_mode_t m);
        return m[1] == m[0];
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with registered rise/fall pulses for one asynchronous pin.
// Pulses appear three clocks after the pin changes; everything holds while ena is low.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            prev <= RST_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else if (ena) begin
            meta <= din;
            sync <= meta;
            prev <= sync;
            rise <= sync & ~prev;
            fall <= ~sync & prev;
        end
    end

    assign dout = sync;

endmodule

// File: rtl/spi_peripheral_burst.sv
// SPI target with command byte, burst read/write, address auto-increment and abort reporting.
// Register strobes follow word completion by 2-3 clocks; the SPI host cannot be stalled.
module spi_peripheral_burst
    import spi_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int REG_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [1:0]        mode,
    input  logic              spi_cs_n,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] addr,
    output logic [REG_W-1:0]  wdata,
    output logic              we,
    output logic              re,
    input  logic [REG_W-1:0]  rdata,
    input  logic [7:0]        status,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(REG_W + 1);

    logic cs_s, cs_rise, cs_fall;
    logic sck_s_unused, sck_rise, sck_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst(rst), .ena(ena), .din(spi_cs_n),
        .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
        .clk(clk), .rst(rst), .ena(ena), .din(spi_clk),
        .dout(sck_s_unused), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .ena(ena), .din(spi_mosi),
        .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    state_t           state;
    spi_mode_t        mode_q;
    logic [REG_W-1:0] tx;
    logic [REG_W-1:0] rx;
    logic [CNT_W-1:0] bit_cnt;
    logic             word_done;
    logic             rd_req;
    logic             ld_pend;
    logic             armed;
    logic [1:0]       settle;

    logic             active, smp_edge, chg_edge, sof, eof;
    logic [CNT_W-1:0] word_len;

    always_comb begin
        active   = (state != ST_IDLE) && !cs_s;
        smp_edge = active && (samples_on_rise(mode_q) ? sck_rise : sck_fall);
        chg_edge = active && (samples_on_rise(mode_q) ? sck_fall : sck_rise);
        sof      = cs_fall && armed && (state == ST_IDLE);
        eof      = cs_rise && (state != ST_IDLE);
        word_len = (state == ST_CMD) ? CNT_W'(CMD_W) : CNT_W'(REG_W);
    end

    assign spi_miso = tx[REG_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            mode_q    <= '0;
            tx        <= '0;
            rx        <= '0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
            rd_req    <= 1'b0;
            ld_pend   <= 1'b0;
            armed     <= 1'b0;
            settle    <= '0;
            addr      <= '0;
            wdata     <= '0;
            we        <= 1'b0;
            re        <= 1'b0;
            frame_err <= 1'b0;
        end else if (ena) begin
            we        <= 1'b0;
            re        <= 1'b0;
            frame_err <= 1'b0;
            word_done <= 1'b0;
            rd_req    <= 1'b0;
            ld_pend   <= re;

            // The synchronised cs_n only reflects the pin two clocks after reset; a frame
            // left open across reset must see cs_n high before a new start is accepted.
            if (settle != 2'd2) settle <= settle + 2'd1;
            else if (cs_s)      armed  <= 1'b1;

            if (we)     addr <= addr + ADDR_W'(1);
            if (rd_req) re   <= 1'b1;

            if (ld_pend)                         tx <= rdata;
            else if (chg_edge && bit_cnt != '0)  tx <= {tx[REG_W-2:0], 1'b0};

            if (smp_edge) begin
                rx <= {rx[REG_W-2:0], mosi_s};
                if (bit_cnt == word_len - CNT_W'(1)) begin
                    bit_cnt   <= '0;
                    word_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end

            if (word_done) begin
                case (state)
                    ST_CMD: begin
                        addr <= rx[ADDR_W-1:0];
                        if (rx[CMD_RW_BIT]) begin
                            state <= ST_WRITE;
                        end else begin
                            state <= ST_READ;
                            re    <= 1'b1;
                        end
                    end
                    ST_WRITE: begin
                        wdata <= rx;
                        we    <= 1'b1;
                    end
                    ST_READ: begin
                        addr   <= addr + ADDR_W'(1);
                        rd_req <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (sof) begin
                state   <= ST_CMD;
                mode_q  <= mode;
                tx      <= REG_W'(status) << (REG_W - CMD_W);
                bit_cnt <= '0;
            end

            // End of frame overrides any state change from a word finishing in the same cycle.
            if (eof) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
                if (bit_cnt != '0) frame_err <= 1'b1;
            end
        end
    end

endmodule
